// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared state encoding and default sizing for the sequential CLA adder
package cla_pkg;

   localparam int DEF_SLICE_W = 16;
   localparam int DEF_NSLICE  = 4;

   // 2'd3 is unused and is steered back to ST_IDLE by the controller
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla_nbit.sv
// rtl/cla_nbit.sv - n-bit carry-lookahead adder slice built from generate/propagate terms
module cla_nbit #(
   parameter int n = 16
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         ci,
   output logic [n-1:0] s,
   output logic         co
);

   logic [n-1:0] g;
   logic [n-1:0] p;
   logic [n:0]   c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < n; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      s  = p ^ c[n-1:0];
      co = c[n];
   end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// rtl/cla_seq_adder_ctrl.sv - wide add/sub that reuses one cla_nbit slice over NSLICE cycles
module cla_seq_adder_ctrl
   import cla_pkg::*;
#(
   parameter int  SLICE_W = DEF_SLICE_W,
   parameter int  NSLICE  = DEF_NSLICE,
   localparam int TW      = SLICE_W * NSLICE
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [TW-1:0] a,
   input  logic [TW-1:0] b,
   input  logic          ci,
   input  logic          sub,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [TW-1:0] sum,
   output logic          co,
   output logic          ovf
);

   localparam int            CW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   state_t                          state_q, state_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic                            carry_q, carry_d;
   logic [NSLICE-1:0][SLICE_W-1:0]  op_a_q, op_a_d;
   logic [NSLICE-1:0][SLICE_W-1:0]  op_b_q, op_b_d;
   logic [NSLICE-1:0][SLICE_W-1:0]  sum_q, sum_d;
   logic                            co_q, co_d;
   logic                            ovf_q, ovf_d;
   logic                            in_ready_q, in_ready_d;
   logic                            out_valid_q, out_valid_d;

   logic [SLICE_W-1:0]              slice_a, slice_b, slice_s;
   logic                            slice_co;

   assign slice_a = op_a_q[cnt_q];
   assign slice_b = op_b_q[cnt_q];

   cla_nbit #(.n(SLICE_W)) u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sum_d   = sum_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               // Subtraction is A + ~B + ~borrow, so the slice only ever adds
               op_a_d  = a;
               op_b_d  = sub ? ~b : b;
               carry_d = ci ^ sub;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[cnt_q] = slice_s;
            carry_d      = slice_co;
            if (cnt_q == LAST) begin
               co_d    = slice_co;
               ovf_d   = op_a_q[NSLICE-1][SLICE_W-1] ^ op_b_q[NSLICE-1][SLICE_W-1]
                       ^ slice_s[SLICE_W-1] ^ slice_co;
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         sum_q       <= '0;
         co_q        <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         sum_q       <= sum_d;
         co_q        <= co_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign co        = co_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb/tb_cla_seq_adder_ctrl.sv - scoreboard bench for the sequential CLA add/sub controller
module tb_cla_seq_adder_ctrl;

   localparam int TW = 64;

   typedef struct packed {
      logic          ovf;
      logic          co;
      logic [TW-1:0] sum;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [TW-1:0] a = '0;
   logic [TW-1:0] b = '0;
   logic          ci = 1'b0;
   logic          sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [TW-1:0] sum;
   logic          co;
   logic          ovf;

   int   checks = 0;
   int   failures = 0;
   int   sent = 0;
   int   got = 0;
   bit   rand_ready = 1'b0;
   res_t sb[$];

   cla_seq_adder_ctrl #(.SLICE_W(16), .NSLICE(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Golden result from plain wide arithmetic; co is the raw adder carry (no-borrow on sub)
   function automatic res_t model(input logic [TW-1:0] x, input logic [TW-1:0] y,
                                  input logic c, input logic s);
      res_t        r;
      logic [65:0] tot;
      logic [65:0] sr;
      logic [65:0] sx;
      logic [65:0] sy;
      sx = {{2{x[TW-1]}}, x};
      sy = {{2{y[TW-1]}}, y};
      if (!s) begin
         tot  = {2'b00, x} + {2'b00, y} + {65'd0, c};
         sr   = sx + sy + {65'd0, c};
         r.co = tot[64];
      end else begin
         tot  = {2'b00, x} - {2'b00, y} - {65'd0, c};
         sr   = sx - sy - {65'd0, c};
         r.co = ~tot[65];
      end
      r.sum = tot[TW-1:0];
      r.ovf = (sr[65:63] != 3'b000) && (sr[65:63] != 3'b111);
      return r;
   endfunction

   task automatic chk(input bit ok, input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [TW-1:0] rand64();
      logic [TW-1:0] v;
      case ($urandom_range(7))
         0:       v = '0;
         1:       v = '1;
         2:       v = 64'h8000_0000_0000_0000;
         3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // Monitor: every output handshake must match the oldest outstanding expectation
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_output", {ovf, co, sum}, 0);
            end else begin
               e = sb.pop_front();
               got++;
               chk({ovf, co, sum} == e, "result", {ovf, co, sum}, e);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(3) != 0);
      end
   end

   // Leaves in_valid high; returns 1 time unit after the accept edge
   task automatic send(input logic [TW-1:0] x, input logic [TW-1:0] y,
                       input logic c, input logic s);
      int n;
      n = 0;
      a = x; b = y; ci = c; sub = s; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(model(x, y, c, s));
            sent++;
            break;
         end
         n++;
         if (n > 50) begin
            chk(1'b0, "accept_timeout", n, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic dir(input logic [TW-1:0] x, input logic [TW-1:0] y,
                      input logic c, input logic s);
      int lat;
      send(x, y, c, s);
      in_valid = 1'b0;
      for (lat = 1; lat <= 20; lat++) begin
         @(posedge clk);
         #1;
         chk(in_ready == 1'b0, "in_ready_busy", in_ready, 0);
         if (out_valid) break;
      end
      chk(lat == 4, "latency", lat, 4);
      @(posedge clk);
      #1;
      chk(in_ready == 1'b1 && out_valid == 1'b0, "idle_after_done", {in_ready, out_valid}, 2'b10);
   endtask

   initial begin
      res_t e;
      int   n;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
      chk({ovf, co, sum} == '0, "reset_result", {ovf, co, sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);

      dir(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
      dir(64'd5, 64'd7, 1'b0, 1'b1);
      dir(64'd7, 64'd5, 1'b0, 1'b1);
      dir(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      dir(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);

      // Backpressure: result must hold while inputs churn
      out_ready = 1'b0;
      send(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
      in_valid = 1'b0;
      e = model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(out_valid == 1'b1, "bp_done_timeout", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         chk(out_valid == 1'b1 && in_ready == 1'b0, "bp_handshake", {out_valid, in_ready}, 2'b10);
         chk({ovf, co, sum} == e, "bp_hold", {ovf, co, sum}, e);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         in_valid = $urandom_range(1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk(out_valid == 1'b0 && in_ready == 1'b1, "bp_release", {out_valid, in_ready}, 2'b01);

      // Reset in the middle of RUN discards the op
      send(64'h0F0F_0F0F_0F0F_0F0F, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk(out_valid == 1'b0 && in_ready == 1'b1, "rst_mid_flags", {out_valid, in_ready}, 2'b01);
      chk(sum == '0, "rst_mid_sum", sum, 0);
      sent -= sb.size();
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk(out_valid == 1'b0 && in_ready == 1'b1 && sum == '0, "rst_release",
          {out_valid, in_ready, sum}, {2'b01, 64'h0});
      dir(64'd1, 64'd1, 1'b0, 1'b0);

      // Back-to-back random ops with random consumer stalls
      rand_ready = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         send(rand64(), rand64(), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      in_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      chk(sb.size() == 0, "drain", sb.size(), 0);
      chk(got == sent, "op_count", got, sent);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
